// File: rtl/game_referee.sv
// game_referee -- referee for a two-snake game on a GRID_W x GRID_H playfield.
//
// A round starts by clearing the external occupancy RAM. The block then
// waits for game steps. On each accepted step it reads the occupancy of both
// heads, decides whether either head crashed, and then either declares a
// result or marks both head cells as occupied.
//
// Ports
//   Clk, Reset                 clock (rising edge), async active-high reset
//   round_start                pulse: begin a new round (highest priority)
//   frame_tick, pause          step pulse; ignored while pause is high
//   head{1,2}_{x,y}            snake head cell coordinates
//   occ_rd_addr / occ_rd_data  occupancy RAM read port, {y,x}, 1-cycle latency
//   occ_we/_wr_addr/_wr_data   occupancy RAM write port
//   player1wins/player2wins/tie  registered round result levels
//   busy                       high outside IDLE, WAIT_TICK and DONE
//   step_count                 completed steps, saturating
module game_referee #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 48
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        round_start,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic [5:0]  head1_x,
  input  logic [5:0]  head1_y,
  input  logic [5:0]  head2_x,
  input  logic [5:0]  head2_y,
  output logic [11:0] occ_rd_addr,
  input  logic        occ_rd_data,
  output logic        occ_we,
  output logic [11:0] occ_wr_addr,
  output logic        occ_wr_data,
  output logic        player1wins,
  output logic        player2wins,
  output logic        tie,
  output logic        busy,
  output logic [15:0] step_count
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] CLEAR     = 4'd1;
  localparam logic [3:0] WAIT_TICK = 4'd2;
  localparam logic [3:0] RD1       = 4'd3;
  localparam logic [3:0] RD2       = 4'd4;
  localparam logic [3:0] EVAL      = 4'd5;
  localparam logic [3:0] MARK1     = 4'd6;
  localparam logic [3:0] MARK2     = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;

  localparam logic [5:0] LAST_X = 6'(GRID_W - 1);
  localparam logic [5:0] LAST_Y = 6'(GRID_H - 1);

  logic [3:0] state;
  logic [5:0] idx_x, idx_y;
  logic [5:0] h1x, h1y, h2x, h2y;
  logic       occ1_q;

  logic oob1, oob2, same_cell, crash1, crash2;

  // Head 1 occupancy was captured in RD2; head 2 occupancy is on the read
  // port during EVAL. An out-of-bounds address aliases some other cell, so
  // its occupancy bit is masked off.
  always_comb begin
    oob1      = (int'(h1x) >= GRID_W) || (int'(h1y) >= GRID_H);
    oob2      = (int'(h2x) >= GRID_W) || (int'(h2y) >= GRID_H);
    same_cell = (h1x == h2x) && (h1y == h2y);
    crash1    = oob1 || (occ1_q && !oob1) || same_cell;
    crash2    = oob2 || (occ_rd_data && !oob2) || same_cell;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      idx_x       <= '0;
      idx_y       <= '0;
      h1x         <= '0;
      h1y         <= '0;
      h2x         <= '0;
      h2y         <= '0;
      occ1_q      <= 1'b0;
      player1wins <= 1'b0;
      player2wins <= 1'b0;
      tie         <= 1'b0;
      step_count  <= '0;
    end else if (round_start) begin
      state       <= CLEAR;
      idx_x       <= '0;
      idx_y       <= '0;
      player1wins <= 1'b0;
      player2wins <= 1'b0;
      tie         <= 1'b0;
      step_count  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (idx_x == LAST_X) begin
            idx_x <= '0;
            idx_y <= idx_y + 6'd1;
          end else begin
            idx_x <= idx_x + 6'd1;
          end
          if (idx_x == LAST_X && idx_y == LAST_Y) state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (frame_tick && !pause) begin
            h1x   <= head1_x;
            h1y   <= head1_y;
            h2x   <= head2_x;
            h2y   <= head2_y;
            state <= RD1;
          end
        end
        RD1: state <= RD2;
        RD2: begin
          occ1_q <= occ_rd_data;
          state  <= EVAL;
        end
        EVAL: begin
          if (crash1 || crash2) begin
            tie         <= crash1 && crash2;
            player2wins <= crash1 && !crash2;
            player1wins <= crash2 && !crash1;
            state       <= DONE;
          end else begin
            state <= MARK1;
          end
        end
        MARK1: state <= MARK2;
        MARK2: begin
          if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
          state <= WAIT_TICK;
        end
        IDLE:    state <= IDLE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port drive is purely a function of state so it is quiet (all zero)
  // in IDLE, WAIT_TICK and DONE, including immediately on Reset.
  always_comb begin
    occ_rd_addr = '0;
    occ_we      = 1'b0;
    occ_wr_addr = '0;
    occ_wr_data = 1'b0;
    busy        = 1'b1;
    case (state)
      CLEAR: begin
        occ_we      = 1'b1;
        occ_wr_addr = {idx_y, idx_x};
      end
      RD1: occ_rd_addr = {h1y, h1x};
      RD2: occ_rd_addr = {h2y, h2x};
      MARK1: begin
        occ_we      = 1'b1;
        occ_wr_addr = {h1y, h1x};
        occ_wr_data = 1'b1;
      end
      MARK2: begin
        occ_we      = 1'b1;
        occ_wr_addr = {h2y, h2x};
        occ_wr_data = 1'b1;
      end
      IDLE, WAIT_TICK, DONE: busy = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_referee.sv
// Bench for game_referee: behavioral occupancy RAM, write scoreboard checked
// by a negedge monitor, and directed step scenarios with hand-computed values.
module tb_game_referee;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        round_start = 1'b0;
  logic        frame_tick = 1'b0;
  logic        pause = 1'b0;
  logic [5:0]  head1_x = '0, head1_y = '0, head2_x = '0, head2_y = '0;
  logic [11:0] occ_rd_addr, occ_wr_addr;
  logic        occ_rd_data, occ_we, occ_wr_data;
  logic        player1wins, player2wins, tie, busy;
  logic [15:0] step_count;

  game_referee dut (
    .Clk(Clk), .Reset(Reset), .round_start(round_start),
    .frame_tick(frame_tick), .pause(pause),
    .head1_x(head1_x), .head1_y(head1_y), .head2_x(head2_x), .head2_y(head2_y),
    .occ_rd_addr(occ_rd_addr), .occ_rd_data(occ_rd_data),
    .occ_we(occ_we), .occ_wr_addr(occ_wr_addr), .occ_wr_data(occ_wr_data),
    .player1wins(player1wins), .player2wins(player2wins), .tie(tie),
    .busy(busy), .step_count(step_count)
  );

  always #5 Clk = ~Clk;

  // Occupancy RAM starts all-ones so a missing clear shows up as crashes.
  bit   mem [0:4095] = '{default: 1'b1};
  logic rd_q = 1'b0;
  assign occ_rd_data = rd_q;
  always @(posedge Clk) begin
    if (occ_we) mem[occ_wr_addr] <= occ_wr_data;
    rd_q <= mem[occ_rd_addr];
  end

  int total = 0;
  int passed = 0;
  logic [12:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every RAM write must match the next expected write.
  always @(negedge Clk) begin
    if (occ_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                 occ_wr_addr, occ_wr_data);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("ram_write", 32'({occ_wr_addr, occ_wr_data}), 32'(e));
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({12'(i), 1'b0});
  endtask

  task automatic push_mark(input int addr);
    exp_q.push_back({12'(addr), 1'b1});
  endtask

  // Leaves the bench in the first CLEAR cycle (index 0).
  task automatic pulse_start();
    round_start = 1'b1;
    step();
    round_start = 1'b0;
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      step();
      n++;
    end
    chk("clear_cycles", 32'(n), 32'd3072);
    chk("busy_after_clear", 32'(busy), 32'd0);
  endtask

  // Leaves the bench in RD1. Heads are scrambled afterwards so only the
  // latched coordinates can give the right answer.
  task automatic do_tick(input int x1, input int y1, input int x2, input int y2);
    head1_x = 6'(x1); head1_y = 6'(y1);
    head2_x = 6'(x2); head2_y = 6'(y2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    head1_x = 6'd63; head1_y = 6'd63; head2_x = 6'd63; head2_y = 6'd63;
  endtask

  task automatic chk_results(input string name, input logic [2:0] exp);
    chk(name, 32'({player1wins, player2wins, tie}), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    step(); step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk_results("rst_results", 3'b000);
    chk("rst_we", 32'(occ_we), 32'd0);
    chk("rst_addrs", 32'({occ_rd_addr, occ_wr_addr}), 32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);
    Reset = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    chk("idle_ignores_tick", 32'(busy), 32'd0);

    // Full clear
    push_clear(3072);
    pulse_start();
    chk("clear_first_addr", 32'(occ_wr_addr), 32'd0);
    wait_clear();

    // Safe step: (5,5)->325, (20,20)->1300
    push_mark(325);
    push_mark(1300);
    do_tick(5, 5, 20, 20);
    chk("rd1_addr", 32'(occ_rd_addr), 32'd325);
    step();
    chk("rd2_addr", 32'(occ_rd_addr), 32'd1300);
    step();
    step();
    chk_results("safe_no_result", 3'b000);
    chk("mark1_t4", 32'({occ_we, occ_wr_addr}), 32'({1'b1, 12'd325}));
    step();
    chk("mark2_t5", 32'({occ_we, occ_wr_addr}), 32'({1'b1, 12'd1300}));
    step();
    chk("safe_busy", 32'(busy), 32'd0);
    chk("safe_step_count", 32'(step_count), 32'd1);

    // Head 2 onto occupied 325 -> player 1 wins
    do_tick(6, 5, 5, 5);
    step(); step(); step();
    chk_results("p1_wins_t4", 3'b100);
    for (int i = 0; i < 100; i++) begin
      do_tick(1, 2, 3, 4);
      step();
    end
    chk_results("p1_wins_held", 3'b100);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_step_count", 32'(step_count), 32'd1);

    // round_start in DONE clears results and restarts CLEAR at 0
    push_clear(3072);
    pulse_start();
    chk_results("restart_results", 3'b000);
    chk("restart_addr", 32'({occ_we, occ_wr_addr}), 32'({1'b1, 12'd0}));
    chk("restart_step_count", 32'(step_count), 32'd0);
    wait_clear();

    // Same cell -> tie
    do_tick(10, 10, 10, 10);
    step(); step(); step();
    chk_results("tie", 3'b001);
    push_clear(3072);
    pulse_start();
    wait_clear();

    // Head 1 out of bounds (y=48) -> player 2 wins
    do_tick(3, 48, 7, 7);
    step(); step(); step();
    chk_results("p2_wins_oob", 3'b010);
    push_clear(3072);
    pulse_start();
    wait_clear();

    // Pause suppresses ticks
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      chk("pause_busy", 32'(busy), 32'd0);
    end
    pause = 1'b0;
    chk("pause_step_count", 32'(step_count), 32'd0);

    // Tick during RD2 is dropped: (1,1)->65, (2,2)->130
    push_mark(65);
    push_mark(130);
    do_tick(1, 1, 2, 2);
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 6; i++) step();
    chk("rd2_tick_busy", 32'(busy), 32'd0);
    chk("rd2_tick_step_count", 32'(step_count), 32'd1);

    // Reset in the middle of CLEAR at index 1000
    push_clear(1000);
    pulse_start();
    for (int i = 0; i < 1000; i++) step();
    chk("clear_idx_1000", 32'(occ_wr_addr), 32'd1000);
    Reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(occ_we), 32'd0);
    chk("mid_rst_addrs", 32'({occ_rd_addr, occ_wr_addr}), 32'd0);
    chk_results("mid_rst_results", 3'b000);
    chk("mid_rst_step_count", 32'(step_count), 32'd0);
    step(); step();
    Reset = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(); step();
    chk("post_rst_idle", 32'({busy, occ_we}), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/game_referee.md
GAME_REFEREE -- requirements
Module: game_referee

Interface
REQ-001 SHALL have parameter GRID_W, default 64, meaning playfield width in cells (x valid 0..GRID_W-1).
REQ-002 SHALL have parameter GRID_H, default 48, meaning playfield height in cells (y valid 0..GRID_H-1).
REQ-003 SHALL have port: Clk  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port: Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: round_start  in  1  one-cycle pulse that begins a new round.
REQ-006 SHALL have port: frame_tick  in  1  one-cycle pulse, one per game step.
REQ-007 SHALL have port: pause  in  1  level; while high, frame_tick is ignored.
REQ-008 SHALL have ports: head1_x, head1_y, head2_x, head2_y  in  6 each  snake head cell coordinates.
REQ-009 SHALL have port: occ_rd_addr  out  12  occupancy RAM read address = {y,x}; RAM returns data one cycle later.
REQ-010 SHALL have port: occ_rd_data  in  1  occupancy bit (1 = cell occupied).
REQ-011 SHALL have ports: occ_we out 1, occ_wr_addr out 12, occ_wr_data out 1  occupancy RAM write port.
REQ-012 SHALL have ports: player1wins, player2wins, tie  out  1 each  registered round result levels.
REQ-013 SHALL have ports: busy out 1 (high in every state except IDLE, WAIT_TICK, DONE); step_count out 16 (completed steps).

Function
REQ-014 SHALL implement states IDLE, CLEAR, WAIT_TICK, RD1, RD2, EVAL, MARK1, MARK2, DONE.
REQ-015 SHALL, on round_start in any state, enter CLEAR next cycle, zero clear index, zero step_count, deassert all results; round_start has priority over all other events.
REQ-016 SHALL, in CLEAR, write occ_wr_data=0 to address {idx_y,idx_x} each cycle for all GRID_W*GRID_H cells in raster order (3072 cycles at defaults), then enter WAIT_TICK.
REQ-017 SHALL, in WAIT_TICK, on frame_tick=1 and pause=0, latch all four head coordinates and enter RD1; frame_tick in any other state or with pause=1 is dropped, no queuing.
REQ-018 SHALL drive occ_rd_addr={head1_y,head1_x} in RD1 and {head2_y,head2_x} in RD2 (latched values); sample head1 occupancy in RD2 and head2 occupancy in EVAL.
REQ-019 SHALL define crashN = head N out of bounds (x>=GRID_W or y>=GRID_H) OR its cell occupied OR head1==head2 (both coordinates); occupancy of an out-of-bounds read is ignored.
REQ-020 SHALL, in EVAL: crash1&crash2 -> tie; crash1 only -> player2wins; crash2 only -> player1wins; any crash -> DONE next cycle with result registered at DONE entry.
REQ-021 SHALL, in EVAL with no crash, go MARK1 (write 1 to head1 cell), MARK2 (write 1 to head2 cell), then WAIT_TICK; step_count increments on MARK2 exit, saturating at 16'hFFFF.
REQ-022 SHALL assert exactly one of player1wins/player2wins/tie in DONE, hold it until round_start or Reset, and never write the RAM outside CLEAR/MARK1/MARK2.
REQ-023 SHALL give latency: frame_tick at cycle t -> RD1 t+1, RD2 t+2, EVAL t+3, DONE or MARK1 t+4, WAIT_TICK t+6 when no crash.
REQ-024 SHALL hold occ_we=0, occ_rd_addr and occ_wr_addr at 0 in IDLE, WAIT_TICK, DONE.

Reset
REQ-025 SHALL, on Reset, asynchronously enter IDLE; player1wins=player2wins=tie=0, busy=0, occ_we=0, addresses=0, step_count=0, clear index=0.
REQ-026 SHALL, on Reset mid-CLEAR or mid-step, abandon the operation with no further RAM writes; only round_start leaves IDLE.

Verification
REQ-027 SHALL cover: round_start -> 3072 writes of 0, addresses 0..3071 ascending, WAIT_TICK at cycle 3073, busy low after.
REQ-028 SHALL cover: heads (5,5),(20,20), empty grid, tick -> no result, cells 325 and 1300 written 1 at t+4/t+5, step_count=1.
REQ-029 SHALL cover: head2 onto occupied cell 325 -> player1wins=1 at t+4, held through 100 further ticks, no writes.
REQ-030 SHALL cover: both heads (10,10) -> tie=1; head1 y=48 with head2 safe -> player2wins=1.
REQ-031 SHALL cover: pause=1 with frame_tick pulses -> no state change; tick during RD2 -> dropped.
REQ-032 SHALL cover: Reset at CLEAR index 1000 -> IDLE, outputs 0; round_start during DONE -> results cleared next cycle, CLEAR restarts at 0.
